// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax tile scheduler and its row-stat bank.
// Latency: n/a (package only).
// Backpressure: n/a.
package softmax_pkg;

  localparam int ROWS      = 16;
  localparam int EXP_SUM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TILE = 3'd1,
    ST_RUN       = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DONE      = 3'd4
  } sched_state_e;

  // Most negative signed value of a d_w-bit word: the identity for a running max.
  function automatic int x_max_init(input int d_w);
    return -(2 ** (d_w - 1));
  endfunction

endpackage

// File: rtl/softmax_row_stats.sv
// 16-row bank of running X_MAX / EXP_SUM statistics for one query block.
// Latency: init/load take effect on the next clock edge; init wins over load.
// Backpressure: none; the bank always accepts init or load.
// Ports: clk/rst_n; init (reset stats to identity); load with ld_x_max/ld_exp_sum;
//        x_max/exp_sum present the current bank contents.
module softmax_row_stats
  import softmax_pkg::*;
#(
  parameter int D_W = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                init,
  input  logic                                load,
  input  logic [ROWS-1:0][D_W-1:0]            ld_x_max,
  input  logic [ROWS-1:0][EXP_SUM_W-1:0]      ld_exp_sum,
  output logic [ROWS-1:0][D_W-1:0]            x_max,
  output logic [ROWS-1:0][EXP_SUM_W-1:0]      exp_sum
);

  localparam logic [D_W-1:0] X_INIT = D_W'(x_max_init(D_W));

  logic [ROWS-1:0][D_W-1:0]       x_max_q, x_max_d;
  logic [ROWS-1:0][EXP_SUM_W-1:0] exp_sum_q, exp_sum_d;

  always_comb begin
    x_max_d   = x_max_q;
    exp_sum_d = exp_sum_q;
    if (init) begin
      x_max_d   = {ROWS{X_INIT}};
      exp_sum_d = '0;
    end else if (load) begin
      x_max_d   = ld_x_max;
      exp_sum_d = ld_exp_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_max_q   <= {ROWS{X_INIT}};
      exp_sum_q <= '0;
    end else begin
      x_max_q   <= x_max_d;
      exp_sum_q <= exp_sum_d;
    end
  end

  assign x_max   = x_max_q;
  assign exp_sum = exp_sum_q;

endmodule

// File: rtl/softmax_tile_scheduler.sv
// Sequences the 16-row online-softmax array over NTILE key tiles of one query block.
// Latency: tile accept -> O_SM_START 1 cycle; I_SM_VLD -> O_OUT_VLD 1 cycle; last I_OUT_RDY -> O_DONE 1 cycle.
// Backpressure: one tile in flight; O_TILE_RDY only in WAIT_TILE, HOLD stalls on I_OUT_RDY low.
// Ports: I_START/I_NTILE begin a block; I_TILE_VLD/O_TILE_RDY upstream handshake;
//        O_SM_START, I_SM_VLD, I_SM_*/O_SM_* array control and stat feedback;
//        O_OUT_VLD/I_OUT_RDY/O_TILE_IDX/O_LAST downstream; O_BUSY/O_DONE/O_ERR status.
module softmax_tile_scheduler
  import softmax_pkg::*;
#(
  parameter int D_W       = 8,
  parameter int MAX_NTILE = 64,
  parameter int TIMEOUT   = 1024,
  parameter int TW        = $clog2(MAX_NTILE + 1)
) (
  input  logic                            I_CLK,
  input  logic                            I_RST_N,
  input  logic                            I_START,
  input  logic [TW-1:0]                   I_NTILE,
  input  logic                            I_TILE_VLD,
  output logic                            O_TILE_RDY,
  output logic                            O_SM_START,
  input  logic                            I_SM_VLD,
  input  logic [ROWS-1:0][D_W-1:0]        I_SM_X_MAX,
  input  logic [ROWS-1:0][EXP_SUM_W-1:0]  I_SM_EXP_SUM,
  output logic [ROWS-1:0][D_W-1:0]        O_SM_X_MAX,
  output logic [ROWS-1:0][EXP_SUM_W-1:0]  O_SM_EXP_SUM,
  output logic                            O_OUT_VLD,
  input  logic                            I_OUT_RDY,
  output logic [TW-1:0]                   O_TILE_IDX,
  output logic                            O_LAST,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic                            O_ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_e  state_q, state_d;
  logic [TW-1:0] ntile_q, ntile_d;
  logic [TW-1:0] idx_q, idx_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tile_rdy_q, tile_rdy_d;
  logic          sm_start_q, sm_start_d;
  logic          out_vld_q, out_vld_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bank_init, bank_load;

  always_comb begin
    state_d   = state_q;
    ntile_d   = ntile_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    bank_init = 1'b0;
    bank_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          err_d     = 1'b0;
          bank_init = 1'b1;
          idx_d     = '0;
          ntile_d   = (I_NTILE > TW'(MAX_NTILE)) ? TW'(MAX_NTILE) : I_NTILE;
          state_d   = (I_NTILE == '0) ? ST_DONE : ST_WAIT_TILE;
        end
      end
      ST_WAIT_TILE: begin
        if (I_TILE_VLD) begin
          tmo_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A result arriving on the final allowed cycle still counts as success.
        if (I_SM_VLD) begin
          bank_load = 1'b1;
          state_d   = ST_HOLD;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (I_OUT_RDY) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == ntile_q) ? ST_DONE : ST_WAIT_TILE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    tile_rdy_d = (state_d == ST_WAIT_TILE);
    sm_start_d = (state_d == ST_RUN);
    out_vld_d  = (state_d == ST_HOLD);
    last_d     = (state_d == ST_HOLD) && (idx_d + 1'b1 == ntile_d);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= ST_IDLE;
      ntile_q    <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      tile_rdy_q <= 1'b0;
      sm_start_q <= 1'b0;
      out_vld_q  <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ntile_q    <= ntile_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      tile_rdy_q <= tile_rdy_d;
      sm_start_q <= sm_start_d;
      out_vld_q  <= out_vld_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  softmax_row_stats #(
    .D_W (D_W)
  ) u_row_stats (
    .clk        (I_CLK),
    .rst_n      (I_RST_N),
    .init       (bank_init),
    .load       (bank_load),
    .ld_x_max   (I_SM_X_MAX),
    .ld_exp_sum (I_SM_EXP_SUM),
    .x_max      (O_SM_X_MAX),
    .exp_sum    (O_SM_EXP_SUM)
  );

  assign O_TILE_RDY = tile_rdy_q;
  assign O_SM_START = sm_start_q;
  assign O_OUT_VLD  = out_vld_q;
  assign O_TILE_IDX = idx_q;
  assign O_LAST     = last_q;
  assign O_BUSY     = busy_q;
  assign O_DONE     = done_q;
  assign O_ERR      = err_q;

endmodule
